// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - load/data bus and display pin bundle for seg7_scan_driver
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp_in;
    logic                  lzb_en;
    logic [6:0]            seg;
    logic                  dp_n;
    logic [DIGITS-1:0]     an_n;
    logic                  pending;
    logic                  frame_tick;

    modport master (
        output load, data, dp_in, lzb_en,
        input  seg, dp_n, an_n, pending, frame_tick
    );

    modport slave (
        input  load, data, dp_in, lzb_en,
        output seg, dp_n, an_n, pending, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed common-anode 7-segment driver with frame-synchronous updates
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int DIV      = 1000,
    parameter bit HEX_MODE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_driver_if.slave   bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_pend_data;
    logic [DIGITS-1:0]     r_pend_dp;
    logic [4*DIGITS-1:0]   r_disp_data;
    logic [DIGITS-1:0]     r_disp_dp;
    logic                  r_pending;
    logic [6:0]            r_seg;
    logic                  r_dp_n;
    logic [DIGITS-1:0]     r_an_n;
    logic                  r_frame_tick;

    logic                  w_cnt_wrap;
    logic                  w_idx_wrap;
    logic                  w_commit;
    logic [3:0]            w_code;
    logic                  w_dp;
    logic                  w_blank;
    logic                  w_zero_above;
    logic [DIGITS-1:0]     w_an_n;
    logic [6:0]            w_seg;
    logic                  w_dp_n;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            4'd10:   s = HEX_MODE ? 7'b0001000 : 7'b1111110;
            4'd11:   s = HEX_MODE ? 7'b1100000 : 7'b1111110;
            4'd12:   s = HEX_MODE ? 7'b0110001 : 7'b1111110;
            4'd13:   s = HEX_MODE ? 7'b1000010 : 7'b1111110;
            4'd14:   s = HEX_MODE ? 7'b0110000 : 7'b1111110;
            default: s = HEX_MODE ? 7'b0111000 : 7'b1111110;
        endcase
        return s;
    endfunction

    assign w_cnt_wrap = (r_cnt == CW'(DIV - 1));
    assign w_idx_wrap = (r_idx == IW'(DIGITS - 1));
    assign w_commit   = w_cnt_wrap && w_idx_wrap;

    // Blanking walks from the MSD downward: digit i blanks only if it and every digit above it are zero.
    always_comb begin
        w_code       = 4'd0;
        w_dp         = 1'b0;
        w_blank      = 1'b0;
        w_zero_above = 1'b1;
        w_an_n       = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_disp_data[4*i +: 4] == 4'd0);
            if (r_idx == IW'(i)) begin
                w_code  = r_disp_data[4*i +: 4];
                w_dp    = r_disp_dp[i];
                w_blank = bus.lzb_en && (i > 0) && w_zero_above;
                if (r_cnt != '0) begin
                    w_an_n[i] = 1'b0;
                end
            end
        end
        if (r_cnt == '0) begin
            w_seg  = 7'b1111111;
            w_dp_n = 1'b1;
        end else begin
            w_seg  = w_blank ? 7'b1111111 : decode(w_code);
            w_dp_n = ~w_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_disp_data  <= '0;
            r_disp_dp    <= '0;
            r_pending    <= 1'b0;
            r_seg        <= 7'b1111111;
            r_dp_n       <= 1'b1;
            r_an_n       <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
            if (w_cnt_wrap) begin
                r_idx <= w_idx_wrap ? '0 : r_idx + 1'b1;
            end
            // A load on the commit cycle goes straight to the display and never marks pending.
            if (w_commit) begin
                r_pending <= 1'b0;
                if (bus.load) begin
                    r_disp_data <= bus.data;
                    r_disp_dp   <= bus.dp_in;
                end else if (r_pending) begin
                    r_disp_data <= r_pend_data;
                    r_disp_dp   <= r_pend_dp;
                end
            end else if (bus.load) begin
                r_pend_data <= bus.data;
                r_pend_dp   <= bus.dp_in;
                r_pending   <= 1'b1;
            end
            r_seg        <= w_seg;
            r_dp_n       <= w_dp_n;
            r_an_n       <= w_an_n;
            r_frame_tick <= w_commit;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp_n       = r_dp_n;
    assign bus.an_n       = r_an_n;
    assign bus.pending    = r_pending;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench, decimal and hex instances side by side
module tb_seg7_scan_driver;
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SM = 7'b1111110;
    localparam logic [6:0] HA = 7'b0001000;
    localparam logic [6:0] HD = 7'b1000010;
    localparam logic [6:0] HE = 7'b0110000;
    localparam logic [6:0] HF = 7'b0111000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    seg7_scan_driver_if #(.DIGITS(4)) bus0 ();
    seg7_scan_driver_if #(.DIGITS(4)) bus1 ();

    assign bus1.load   = bus0.load;
    assign bus1.data   = bus0.data;
    assign bus1.dp_in  = bus0.dp_in;
    assign bus1.lzb_en = bus0.lzb_en;

    seg7_scan_driver #(.DIGITS(4), .DIV(4), .HEX_MODE(1'b0)) u_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    seg7_scan_driver #(.DIGITS(4), .DIV(4), .HEX_MODE(1'b1)) u_hex (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic advance_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        bus0.load  = 1'b1;
        bus0.data  = d;
        bus0.dp_in = dp;
        tick();
        bus0.load  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an_n"}, 32'(bus0.an_n), 32'hF);
        chk({tag, "_seg"}, 32'(bus0.seg), 32'(SB));
        chk({tag, "_dp_n"}, 32'(bus0.dp_n), 32'd1);
        chk({tag, "_pending"}, 32'(bus0.pending), 32'd0);
        chk({tag, "_frame_tick"}, 32'(bus0.frame_tick), 32'd0);
    endtask

    // Call with cyc at a frame boundary; walks one full 16-cycle frame of both DUTs.
    task automatic frame_check(input string tag,
                               input logic [6:0] d3, input logic [6:0] d2,
                               input logic [6:0] d1, input logic [6:0] d0,
                               input logic [6:0] h3, input logic [6:0] h2,
                               input logic [6:0] h1, input logic [6:0] h0,
                               input logic [3:0] dp);
        logic [6:0] dec_exp [4];
        logic [6:0] hex_exp [4];
        logic [3:0] an_exp;
        logic [6:0] sd, sh;
        logic       dpn_exp;
        dec_exp = '{d0, d1, d2, d3};
        hex_exp = '{h0, h1, h2, h3};
        for (int j = 0; j < 16; j++) begin
            int c, k;
            tick();
            c = j % 4;
            k = j / 4;
            if (c == 0) begin
                an_exp  = 4'hF;
                sd      = SB;
                sh      = SB;
                dpn_exp = 1'b1;
            end else begin
                an_exp  = ~(4'b0001 << k);
                sd      = dec_exp[k];
                sh      = hex_exp[k];
                dpn_exp = ~dp[k];
            end
            chk({tag, "_an_n"}, 32'(bus0.an_n), 32'(an_exp));
            chk({tag, "_seg_dec"}, 32'(bus0.seg), 32'(sd));
            chk({tag, "_seg_hex"}, 32'(bus1.seg), 32'(sh));
            chk({tag, "_dp_n"}, 32'(bus0.dp_n), 32'(dpn_exp));
            chk({tag, "_frame_tick"}, 32'(bus0.frame_tick), (j == 15) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        bus0.load   = 1'b0;
        bus0.data   = '0;
        bus0.dp_in  = '0;
        bus0.lzb_en = 1'b0;

        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        cyc = 0;
        tick();
        chk("first_blank_an_n", 32'(bus0.an_n), 32'hF);
        tick();
        chk("first_drive_an_n", 32'(bus0.an_n), 32'hE);
        chk("first_drive_seg", 32'(bus0.seg), 32'(S0));
        advance_to(16);
        frame_check("idle", S0, S0, S0, S0, S0, S0, S0, S0, 4'b0000);

        advance_to(37);
        do_load(16'h1234, 4'b0100);
        chk("load_pending", 32'(bus0.pending), 32'd1);
        advance_to(47);
        chk("pending_before_commit", 32'(bus0.pending), 32'd1);
        tick();
        chk("pending_after_commit", 32'(bus0.pending), 32'd0);
        chk("commit_frame_tick", 32'(bus0.frame_tick), 32'd1);
        frame_check("d1234", S1, S2, S3, S4, S1, S2, S3, S4, 4'b0100);

        bus0.lzb_en = 1'b1;
        do_load(16'h0050, 4'b0000);
        advance_to(80);
        frame_check("lzb0050", SB, SB, S5, S0, SB, SB, S5, S0, 4'b0000);
        do_load(16'h0000, 4'b1000);
        advance_to(112);
        frame_check("lzb0000", SB, SB, SB, S0, SB, SB, SB, S0, 4'b1000);

        bus0.lzb_en = 1'b0;
        do_load(16'hFEDA, 4'b0000);
        advance_to(144);
        frame_check("hexFEDA", SM, SM, SM, SM, HF, HE, HD, HA, 4'b0000);

        do_load(16'h1111, 4'b0000);
        advance_to(165);
        do_load(16'h2222, 4'b0000);
        chk("second_load_pending", 32'(bus0.pending), 32'd1);
        advance_to(175);
        do_load(16'h3333, 4'b0000);
        chk("commit_load_pending", 32'(bus0.pending), 32'd0);
        frame_check("d3333", S3, S3, S3, S3, S3, S3, S3, S3, 4'b0000);

        advance_to(194);
        do_load(16'h5555, 4'b1111);
        chk("pre_reset_pending", 32'(bus0.pending), 32'd1);
        advance_to(197);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        cyc = 0;
        tick();
        chk("post_reset_blank_an_n", 32'(bus0.an_n), 32'hF);
        tick();
        chk("post_reset_drive_an_n", 32'(bus0.an_n), 32'hE);
        chk("post_reset_pending", 32'(bus0.pending), 32'd0);
        advance_to(16);
        frame_check("post_reset", S0, S0, S0, S0, S0, S0, S0, S0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
